// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable generator and S1..S6 / P1..P2 machine-cycle sequencer.
// Optional build macro CLK_DIV_CTRL_SYNC_MC_EN: apply new divisors only at machine-cycle end while running.
module clk_div_ctrl #(
  parameter int CNT_W   = 5,
  parameter int DEF_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_req,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_busy,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic [CNT_W-1:0] cur_div,
  output logic             tick,
  output logic             phase,
  output logic [2:0]       state,
  output logic             mc_end
);

  // Handshake: cfg_req is a single-cycle strobe sampled only while IDLE;
  // cfg_busy stays high from the latch edge until the edge that pulses cfg_ack.
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} cfg_st_t;

  localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO      = '0;

  cfg_st_t          fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             tick_q, tick_d;
  logic             phase_q, phase_d;
  logic [2:0]       state_q, state_d;
  logic             mc_end_q, mc_end_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             tick_set;
  logic             apply_ok;

  always_comb begin
    tick_set = run && (cnt_q == cur_div_q - ONE);
`ifdef CLK_DIV_CTRL_SYNC_MC_EN
    // Hold off until the tick that closes S6P2 so every machine cycle is uniform.
    apply_ok = run ? (tick_set && phase_q && (state_q == 3'd5)) : 1'b1;
`else
    apply_ok = tick_set || !run;
`endif

    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    tick_d     = tick_set;
    phase_d    = phase_q;
    state_d    = state_q;
    mc_end_d   = 1'b0;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;

    if (run) begin
      cnt_d = tick_set ? ZERO : cnt_q + ONE;
    end

    if (tick_set) begin
      phase_d  = ~phase_q;
      mc_end_d = phase_q && (state_q == 3'd5);
      if (phase_q) begin
        state_d = (state_q == 3'd5) ? 3'd0 : state_q + 3'd1;
      end
    end

    case (fsm_q)
      IDLE: begin
        if (cfg_req) begin
          if (cfg_div == ZERO) begin
            err_d = 1'b1;
          end else begin
            pend_div_d = cfg_div;
            busy_d     = 1'b1;
            fsm_d      = PEND;
          end
        end
      end
      PEND: begin
        // New divisor starts a fresh period; a stalled partial period is dropped.
        if (apply_ok) begin
          cur_div_d = pend_div_q;
          cnt_d     = ZERO;
          ack_d     = 1'b1;
          busy_d    = 1'b0;
          fsm_d     = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      fsm_q      <= IDLE;
      cnt_q      <= ZERO;
      cur_div_q  <= DEF_DIV_V;
      pend_div_q <= DEF_DIV_V;
      tick_q     <= 1'b0;
      phase_q    <= 1'b0;
      state_q    <= 3'd0;
      mc_end_q   <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      tick_q     <= tick_d;
      phase_q    <= phase_d;
      state_q    <= state_d;
      mc_end_q   <= mc_end_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign cfg_busy = busy_q;
  assign cfg_ack  = ack_q;
  assign cfg_err  = err_q;
  assign cur_div  = cur_div_q;
  assign tick     = tick_q;
  assign phase    = phase_q;
  assign state    = state_q;
  assign mc_end   = mc_end_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed timeline, expected output
// events queued by the driver and consumed by an independent monitor.
module tb_clk_div_ctrl;
  localparam int CNT_W = 5;
  localparam int W     = 24;
  localparam logic [1:0] T_ERR  = 2'd1;
  localparam logic [1:0] T_TICK = 2'd2;
  localparam logic [1:0] T_ACK  = 2'd3;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             run;
  logic             cfg_req;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_busy;
  logic             cfg_ack;
  logic             cfg_err;
  logic [CNT_W-1:0] cur_div;
  logic             tick;
  logic             phase;
  logic [2:0]       state;
  logic             mc_end;

  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_ev = 0;
  int n_tick = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  clk_div_ctrl #(.CNT_W(CNT_W), .DEF_DIV(2)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .run      (run),
    .cfg_req  (cfg_req),
    .cfg_div  (cfg_div),
    .cfg_busy (cfg_busy),
    .cfg_ack  (cfg_ack),
    .cfg_err  (cfg_err),
    .cur_div  (cur_div),
    .tick     (tick),
    .phase    (phase),
    .state    (state),
    .mc_end   (mc_end)
  );

  function automatic logic [W-1:0] pack(input logic [1:0] typ, input logic [7:0] gap,
                                        input logic mc, input logic [2:0] st, input logic ph,
                                        input logic [4:0] div, input logic busy);
    return {typ, gap, mc, st, ph, div, busy, 3'b000};
  endfunction

  // ---------------- scoreboard monitor ----------------
  task automatic check_ev(input string name, input logic [W-1:0] act);
    logic [W-1:0] exp;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got unexpected event %h, expected no event", name, cyc, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s at cyc %0d: got %h expected %h (typ,gap,mc,state,phase,div,busy)",
                 name, cyc, act, exp);
      end
    end
  endtask

  always @(negedge clk_in) begin
    if (rst) begin
      last_ev = 0;
    end else begin
      if (cfg_err) check_ev("err", pack(T_ERR, 8'd0, 1'b0, 3'd0, 1'b0, cur_div, cfg_busy));
      if (tick) begin
        check_ev("tick", pack(T_TICK, 8'(cyc - last_ev), mc_end, state, phase, cur_div, 1'b0));
        last_ev = cyc;
      end
      if (cfg_ack) begin
        check_ev("ack", pack(T_ACK, 8'd0, 1'b0, 3'd0, 1'b0, cur_div, cfg_busy));
        last_ev = cyc;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic adv(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sequencer reference: tick n of a run since reset lands in S(n/2 mod 6), phase n mod 2.
  task automatic exp_tick(input int gap, input int div);
    n_tick++;
    exp_q.push_back(pack(T_TICK, 8'(gap), 1'((n_tick % 12) == 0), 3'((n_tick / 2) % 6),
                         1'(n_tick % 2), 5'(div), 1'b0));
  endtask

  task automatic exp_ack(input int div);
    exp_q.push_back(pack(T_ACK, 8'd0, 1'b0, 3'd0, 1'b0, 5'(div), 1'b0));
  endtask

  task automatic exp_err(input int div);
    exp_q.push_back(pack(T_ERR, 8'd0, 1'b0, 3'd0, 1'b0, 5'(div), 1'b0));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cur_div"}, 8'(cur_div), 8'd2);
    chk({tag, "_tick"},    8'(tick), 8'd0);
    chk({tag, "_phase"},   8'(phase), 8'd0);
    chk({tag, "_state"},   8'(state), 8'd0);
    chk({tag, "_busy"},    8'(cfg_busy), 8'd0);
    chk({tag, "_ack"},     8'(cfg_ack), 8'd0);
    chk({tag, "_err"},     8'(cfg_err), 8'd0);
    chk({tag, "_mc_end"},  8'(mc_end), 8'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; run = 1'b0; cfg_req = 1'b0; cfg_div = '0;
    adv(3);
    check_reset_vals("reset");

    // Default divisor 2: twelve ticks make one machine cycle, mc_end on the 12th.
    rst = 1'b0; run = 1'b1;
    for (int k = 0; k < 12; k++) exp_tick(2, 2);
    adv(24);

    // Stopped: latch on one edge, apply on the next.
    run = 1'b0; cfg_req = 1'b1; cfg_div = 5'd5;
    adv(1);
    cfg_req = 1'b0;
    chk("busy_after_latch", 8'(cfg_busy), 8'd1);
    exp_ack(5);
    adv(1);
    run = 1'b1;
    exp_tick(5, 5); exp_tick(5, 5);
    adv(10);

    // Running: change to 4 right after a tick, current 5-cycle period completes.
    cfg_req = 1'b1; cfg_div = 5'd4;
    adv(1);
    cfg_req = 1'b0;
    exp_tick(5, 4); exp_ack(4);
    exp_tick(4, 4); exp_tick(4, 4);
    adv(12);

    // Request 7 at cnt=1, then a second request while pending is ignored.
    adv(1);
    cfg_req = 1'b1; cfg_div = 5'd7;
    adv(1);
    cfg_div = 5'd9;
    adv(1);
    cfg_req = 1'b0;
    chk("busy_pending", 8'(cfg_busy), 8'd1);
    chk("div_pending",  8'(cur_div), 8'd4);
    exp_tick(4, 7); exp_ack(7); exp_tick(7, 7);
    adv(8);

    // Divisor 0 is rejected without disturbing anything.
    cfg_req = 1'b1; cfg_div = 5'd0;
    exp_err(7);
    adv(1);
    cfg_req = 1'b0;
    exp_tick(7, 7);
    adv(6);

    // Maximum divisor 31.
    cfg_req = 1'b1; cfg_div = 5'd31;
    adv(1);
    cfg_req = 1'b0;
    exp_tick(7, 31); exp_ack(31); exp_tick(31, 31); exp_tick(31, 31);
    adv(68);

    // Divisor 6, then stall 3 cycles at cnt=2: period stretches to 9.
    cfg_req = 1'b1; cfg_div = 5'd6;
    adv(1);
    cfg_req = 1'b0;
    exp_tick(31, 6); exp_ack(6);
    adv(32);
    run = 1'b0;
    adv(3);
    run = 1'b1;
    exp_tick(9, 6);
    adv(4);

    // Reset while pending: request is dropped with no ack.
    cfg_req = 1'b1; cfg_div = 5'd3;
    adv(1);
    cfg_req = 1'b0;
    adv(1);
    rst = 1'b1;
    #1;
    check_reset_vals("async_reset");
    adv(3);
    rst = 1'b0;
    n_tick = 0;
    exp_tick(2, 2); exp_tick(2, 2); exp_tick(2, 2);
    adv(6);
    run = 1'b0;
    adv(5);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: got %0d outstanding expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
